// File: rtl/multiplier_8bit.sv
// Shift-add multiply-accumulate: product = multiplicand * multiplier + addend, inverse of the 8-bit divider.
// Latency 9 edges after acceptance (1 with a zero operand); strt is only taken while idle and never queued.
module multiplier_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    input  logic [7:0]  addend,
    output logic [15:0] product,
    output logic        idle
);

    // Encoding shared with the divider so one controller can drive both.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        UNUSED   = 2'b01,
        POSTCALC = 2'b10,
        CALC     = 2'b11
    } state_t;

    state_t      state;
    logic [15:0] acc;
    logic [15:0] mcand_reg;
    logic [7:0]  mplier_reg;
    logic [2:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idle       <= 1'b1;
            product    <= 16'd0;
            acc        <= 16'd0;
            mcand_reg  <= 16'd0;
            mplier_reg <= 8'd0;
            cnt        <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (strt) begin
                        acc        <= {8'd0, addend};
                        mcand_reg  <= {8'd0, multiplicand};
                        mplier_reg <= multiplier;
                        cnt        <= 3'd0;
                        idle       <= 1'b0;
                        // A zero operand leaves only the addend, so skip the scan.
                        if (multiplicand == 8'd0 || multiplier == 8'd0)
                            state <= POSTCALC;
                        else
                            state <= CALC;
                    end
                end
                CALC: begin
                    if (mplier_reg[0])
                        acc <= acc + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt        <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= POSTCALC;
                end
                POSTCALC: begin
                    product <= acc;
                    state   <= IDLE;
                    idle    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule
